// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on Clk, decodes frames for PHY_ADDR,
// issues register read/write strobes. Optional macro MDIO_SLAVE_PRE_SUPPRESS_EN enables preamble suppression.
`timescale 1ns/1ps
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDR     = 5'b00100,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MDC_I,
  input  logic        MDIO_I,
  output logic        MDIO_O,
  output logic        MDIO_T,
  output logic [4:0]  Reg_Addr,
  output logic [15:0] Reg_Wdata,
  output logic        Reg_Wr,
  output logic        Reg_Rd,
  input  logic [15:0] Reg_Rdata,
  output logic        Frame_Err,
  output logic        Busy
);

  localparam int unsigned    PW      = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0]  PRE_MAX = PW'(PREAMBLE_LEN);

  localparam logic [2:0] S_PRE    = 3'd0;
  localparam logic [2:0] S_ST1    = 3'd1;
  localparam logic [2:0] S_OP     = 3'd2;
  localparam logic [2:0] S_PHYAD  = 3'd3;
  localparam logic [2:0] S_REGAD  = 3'd4;
  localparam logic [2:0] S_TA     = 3'd5;
  localparam logic [2:0] S_DATA   = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_s;
  logic                   mdc_q;
  logic                   mdio_s;
  logic                   rise;
  logic                   fall;

  logic [2:0]    state;
  logic [4:0]    bit_cnt;
  logic [PW-1:0] pre_cnt;
  logic          pre_ok;
  logic          is_read;
  logic          op_hi;
  logic [3:0]    addr_sh;
  logic [15:0]   shift;
  logic          rd_d1;
  logic          release_pend;

  // Equal-depth chains keep MDC and MDIO samples aligned.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_q     <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], MDC_I};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], MDIO_I};
      mdc_q     <= mdc_sync[SYNC_STAGES-1];
    end
  end

  assign mdc_s  = mdc_sync[SYNC_STAGES-1];
  assign mdio_s = mdio_sync[SYNC_STAGES-1];
  assign rise   = mdc_s & ~mdc_q;
  assign fall   = ~mdc_s & mdc_q;

`ifdef MDIO_SLAVE_PRE_SUPPRESS_EN
  assign pre_ok = (pre_cnt != '0);
`else
  assign pre_ok = (pre_cnt >= PRE_MAX);
`endif

  assign Busy = (state != S_PRE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= S_PRE;
      bit_cnt      <= '0;
      pre_cnt      <= '0;
      is_read      <= 1'b0;
      op_hi        <= 1'b0;
      addr_sh      <= '0;
      shift        <= '0;
      rd_d1        <= 1'b0;
      release_pend <= 1'b0;
      MDIO_O       <= 1'b0;
      MDIO_T       <= 1'b1;
      Reg_Addr     <= '0;
      Reg_Wdata    <= '0;
      Reg_Wr       <= 1'b0;
      Reg_Rd       <= 1'b0;
      Frame_Err    <= 1'b0;
    end else begin
      Reg_Wr    <= 1'b0;
      Reg_Rd    <= 1'b0;
      Frame_Err <= 1'b0;
      rd_d1     <= Reg_Rd;
      if (rd_d1) begin
        shift <= Reg_Rdata;
      end

      // Pad changes only on MDC fall; read data leaves MSB first.
      if (fall) begin
        if (release_pend) begin
          MDIO_T       <= 1'b1;
          MDIO_O       <= 1'b0;
          release_pend <= 1'b0;
        end else if (state == S_TA && is_read && bit_cnt == 5'd1) begin
          MDIO_T <= 1'b0;
          MDIO_O <= 1'b0;
        end else if (state == S_DATA && is_read) begin
          MDIO_O <= shift[15];
          shift  <= {shift[14:0], 1'b0};
        end
      end

      if (rise) begin
        case (state)
          S_PRE: begin
            if (mdio_s) begin
              if (pre_cnt < PRE_MAX) begin
                pre_cnt <= pre_cnt + 1'b1;
              end
            end else if (pre_ok) begin
              state   <= S_ST1;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          S_ST1: begin
            bit_cnt <= '0;
            if (mdio_s) begin
              state <= S_OP;
            end else begin
              Frame_Err <= 1'b1;
              state     <= S_PRE;
            end
          end
          S_OP: begin
            if (bit_cnt == 5'd0) begin
              op_hi   <= mdio_s;
              bit_cnt <= 5'd1;
            end else begin
              bit_cnt <= '0;
              if (op_hi != mdio_s) begin
                is_read <= op_hi;
                state   <= S_PHYAD;
              end else begin
                Frame_Err <= 1'b1;
                state     <= S_PRE;
              end
            end
          end
          S_PHYAD: begin
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              state   <= ({addr_sh, mdio_s} == PHY_ADDR) ? S_REGAD : S_IGNORE;
            end else begin
              addr_sh <= {addr_sh[2:0], mdio_s};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_REGAD: begin
            if (bit_cnt == 5'd4) begin
              bit_cnt  <= '0;
              Reg_Addr <= {addr_sh, mdio_s};
              Reg_Rd   <= is_read;
              state    <= S_TA;
            end else begin
              addr_sh <= {addr_sh[2:0], mdio_s};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_TA: begin
            if (is_read) begin
              if (bit_cnt == 5'd1) begin
                bit_cnt <= '0;
                state   <= S_DATA;
              end else begin
                bit_cnt <= 5'd1;
              end
            end else if (bit_cnt == 5'd0) begin
              if (mdio_s) begin
                bit_cnt <= 5'd1;
              end else begin
                Frame_Err <= 1'b1;
                state     <= S_PRE;
              end
            end else begin
              bit_cnt <= '0;
              if (!mdio_s) begin
                state <= S_DATA;
              end else begin
                Frame_Err <= 1'b1;
                state     <= S_PRE;
              end
            end
          end
          S_DATA: begin
            if (!is_read) begin
              shift <= {shift[14:0], mdio_s};
            end
            if (bit_cnt == 5'd15) begin
              bit_cnt <= '0;
              state   <= S_PRE;
              if (is_read) begin
                release_pend <= 1'b1;
              end else begin
                Reg_Wdata <= {shift[14:0], mdio_s};
                Reg_Wr    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_IGNORE: begin
            // Foreign frame: REGAD + TA + DATA (23 bits) remain after PHYAD.
            if (bit_cnt == 5'd22) begin
              bit_cnt <= '0;
              state   <= S_PRE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            bit_cnt <= '0;
            state   <= S_PRE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// Self-checking bench for mdio_slave: bit-level MDIO master plus strobe scoreboard.
`timescale 1ns/1ps
module tb_mdio_slave;

  localparam int HALF = 100;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        MDC_I = 1'b0;
  logic        drv = 1'b1;
  logic        mdio_line;
  logic        MDIO_O, MDIO_T;
  logic [4:0]  Reg_Addr;
  logic [15:0] Reg_Wdata;
  logic        Reg_Wr, Reg_Rd;
  logic [15:0] Reg_Rdata = 16'h0000;
  logic        Frame_Err, Busy;

  int checks = 0;
  int passes = 0;
  logic t_low_seen = 1'b0;

  typedef struct {
    int         kind;   // 0 = write, 1 = read, 2 = frame error
    logic [4:0] addr;
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  // Master releases the line (pull-up = drv 1) whenever the slave drives.
  assign mdio_line = MDIO_T ? drv : MDIO_O;

  mdio_slave #(.PHY_ADDR(5'b00100), .SYNC_STAGES(2), .PREAMBLE_LEN(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .MDC_I(MDC_I), .MDIO_I(mdio_line),
    .MDIO_O(MDIO_O), .MDIO_T(MDIO_T), .Reg_Addr(Reg_Addr), .Reg_Wdata(Reg_Wdata),
    .Reg_Wr(Reg_Wr), .Reg_Rd(Reg_Rd), .Reg_Rdata(Reg_Rdata),
    .Frame_Err(Frame_Err), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (MDIO_T === 1'b0) t_low_seen = 1'b1;
    if (Reg_Wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_strobe: unexpected Reg_Wr addr=%h data=%h, required none", Reg_Addr, Reg_Wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != 0 || Reg_Addr !== mon_e.addr || Reg_Wdata !== mon_e.data)
          $display("FAIL wr_strobe: got WR addr=%h data=%h, required kind=%0d addr=%h data=%h",
                   Reg_Addr, Reg_Wdata, mon_e.kind, mon_e.addr, mon_e.data);
        else passes++;
      end
    end
    if (Reg_Rd === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_strobe: unexpected Reg_Rd addr=%h, required none", Reg_Addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != 1 || Reg_Addr !== mon_e.addr || Reg_Wr !== 1'b0)
          $display("FAIL rd_strobe: got RD addr=%h wr=%b, required kind=%0d addr=%h wr=0",
                   Reg_Addr, Reg_Wr, mon_e.kind, mon_e.addr);
        else passes++;
      end
    end
    if (Frame_Err === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame_err: unexpected Frame_Err pulse, required none");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != 2)
          $display("FAIL frame_err: got ERR, required kind=%0d", mon_e.kind);
        else passes++;
      end
    end
  end

  task automatic bit_cycle(input logic b, output logic s);
    MDC_I = 1'b0;
    drv   = b;
    #HALF;
    s     = mdio_line;
    MDC_I = 1'b1;
    #HALF;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) bit_cycle(v[i], s);
  endtask

  task automatic preamble(input int n);
    logic s;
    for (int i = 0; i < n; i++) bit_cycle(1'b1, s);
  endtask

  task automatic send_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d, input int pre);
    preamble(pre);
    send_bits({18'd0, 2'b01, 2'b01, phy, ra, 2'b10}, 16);
    send_bits({16'd0, d}, 16);
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] ra,
                         output logic ta1, output logic ta2, output logic [15:0] d);
    logic s;
    preamble(32);
    send_bits({18'd0, 2'b01, 2'b10, phy, ra}, 14);
    bit_cycle(1'b1, ta1);
    bit_cycle(1'b1, ta2);
    for (int i = 15; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
  endtask

  task automatic do_reset;
    MDC_I = 1'b0;
    drv   = 1'b1;
    #40 Rst_n = 1'b0;
    #40 Rst_n = 1'b1;
    #40;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s: %0d expected strobes missing, required 0", name, exp_q.size());
    else passes++;
  endtask

  task automatic test_reset;
    #30;
    checks++;
    if (MDIO_T !== 1'b1 || MDIO_O !== 1'b0) $display("FAIL reset_pad: T=%b O=%b, required T=1 O=0", MDIO_T, MDIO_O);
    else passes++;
    checks++;
    if (Reg_Wr !== 1'b0 || Reg_Rd !== 1'b0 || Frame_Err !== 1'b0 || Busy !== 1'b0)
      $display("FAIL reset_strobes: wr=%b rd=%b err=%b busy=%b, required all 0", Reg_Wr, Reg_Rd, Frame_Err, Busy);
    else passes++;
    checks++;
    if (Reg_Addr !== 5'd0 || Reg_Wdata !== 16'd0)
      $display("FAIL reset_regs: addr=%h wdata=%h, required 00 0000", Reg_Addr, Reg_Wdata);
    else passes++;
    Rst_n = 1'b1;
    #40;
  endtask

  task automatic test_write;
    t_low_seen = 1'b0;
    exp_q.push_back('{0, 5'd5, 16'hA5C3});
    send_write(5'd4, 5'd5, 16'hA5C3, 32);
    check_drained("write_count");
    checks++;
    if (Reg_Addr !== 5'd5 || Reg_Wdata !== 16'hA5C3)
      $display("FAIL write_regs: addr=%h wdata=%h, required 05 a5c3", Reg_Addr, Reg_Wdata);
    else passes++;
    checks++;
    if (t_low_seen !== 1'b0 || Busy !== 1'b0) $display("FAIL write_pad: tlow=%b busy=%b, required 0 0", t_low_seen, Busy);
    else passes++;
  endtask

  task automatic test_read;
    logic ta1, ta2, s;
    logic [15:0] d;
    Reg_Rdata = 16'h1234;
    exp_q.push_back('{1, 5'd2, 16'h0000});
    do_read(5'd4, 5'd2, ta1, ta2, d);
    checks++;
    if (ta1 !== 1'b1 || ta2 !== 1'b0) $display("FAIL read_ta: ta1=%b ta2=%b, required 1 0", ta1, ta2);
    else passes++;
    checks++;
    if (d !== 16'h1234) $display("FAIL read_data: got %h, required 1234", d);
    else passes++;
    checks++;
    if (MDIO_T !== 1'b0 || Busy !== 1'b0) $display("FAIL read_d0_hold: T=%b busy=%b, required T=0 busy=0", MDIO_T, Busy);
    else passes++;
    bit_cycle(1'b1, s);
    checks++;
    if (MDIO_T !== 1'b1) $display("FAIL read_release: T=%b, required 1", MDIO_T);
    else passes++;
    check_drained("read_count");
  endtask

  task automatic test_ignore;
    t_low_seen = 1'b0;
    preamble(32);
    send_bits({18'd0, 2'b01, 2'b10, 5'd3, 5'd1}, 14);
    checks++;
    if (Busy !== 1'b1) $display("FAIL ignore_busy: busy=%b, required 1", Busy);
    else passes++;
    send_bits({30'd0, 2'b10}, 2);
    send_bits({16'd0, 16'h0F0F}, 16);
    exp_q.push_back('{0, 5'd7, 16'h5A0F});
    send_write(5'd4, 5'd7, 16'h5A0F, 32);
    check_drained("ignore_then_write");
    checks++;
    if (t_low_seen !== 1'b0 || Reg_Wdata !== 16'h5A0F)
      $display("FAIL ignore_pad: tlow=%b wdata=%h, required 0 5a0f", t_low_seen, Reg_Wdata);
    else passes++;
  endtask

  task automatic test_short_preamble;
    logic [15:0] want;
    do_reset();
`ifdef MDIO_SLAVE_PRE_SUPPRESS_EN
    want = 16'h3C3C;
    exp_q.push_back('{0, 5'd6, 16'h3C3C});
`else
    want = 16'h0000;
`endif
    send_write(5'd4, 5'd6, 16'h3C3C, 31);
    check_drained("short_pre_count");
    checks++;
    if (Reg_Wdata !== want) $display("FAIL short_pre_wdata: got %h, required %h", Reg_Wdata, want);
    else passes++;
  endtask

  task automatic test_errors;
    logic [15:0] keep;
    keep = Reg_Wdata;
    t_low_seen = 1'b0;
    exp_q.push_back('{2, 5'd0, 16'h0000});
    preamble(32);
    send_bits({28'd0, 2'b01, 2'b11}, 4);
    check_drained("op11_err");
    exp_q.push_back('{2, 5'd0, 16'h0000});
    preamble(32);
    send_bits({16'd0, 2'b01, 2'b01, 5'd4, 5'd5, 2'b11}, 16);
    check_drained("ta11_err");
    checks++;
    if (Reg_Wdata !== keep || t_low_seen !== 1'b0 || Busy !== 1'b0)
      $display("FAIL err_side_effects: wdata=%h tlow=%b busy=%b, required %h 0 0", Reg_Wdata, t_low_seen, Busy, keep);
    else passes++;
  endtask

  task automatic test_reset_mid_read;
    logic ta1, ta2, s;
    logic [15:0] d;
    logic [7:0] hi;
    Reg_Rdata = 16'h1234;
    exp_q.push_back('{1, 5'd2, 16'h0000});
    preamble(32);
    send_bits({18'd0, 2'b01, 2'b10, 5'd4, 5'd2}, 14);
    bit_cycle(1'b1, s);
    bit_cycle(1'b1, s);
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      hi[i] = s;
    end
    checks++;
    if (hi !== 8'h12) $display("FAIL mid_read_hi: got %h, required 12", hi);
    else passes++;
    MDC_I = 1'b0;
    #50;
    checks++;
    if (MDIO_T !== 1'b0) $display("FAIL mid_read_drive: T=%b, required 0", MDIO_T);
    else passes++;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (MDIO_T !== 1'b1 || MDIO_O !== 1'b0) $display("FAIL reset_release: T=%b O=%b, required 1 0", MDIO_T, MDIO_O);
    else passes++;
    #49 Rst_n = 1'b1;
    #40;
    Reg_Rdata = 16'hBEEF;
    exp_q.push_back('{1, 5'd9, 16'h0000});
    do_read(5'd4, 5'd9, ta1, ta2, d);
    bit_cycle(1'b1, s);
    checks++;
    if (d !== 16'hBEEF || ta2 !== 1'b0 || MDIO_T !== 1'b1)
      $display("FAIL read_after_reset: data=%h ta2=%b T=%b, required beef 0 1", d, ta2, MDIO_T);
    else passes++;
    check_drained("read_after_reset_count");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore();
    test_short_preamble();
    test_errors();
    test_reset_mid_read();
    #200;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
